// File: rtl/uart_cmd_master_if.sv
// uart_cmd_master_if
//
// Bundles the command request, the TX byte stream toward the UART transmitter,
// the RX byte stream from the UART receiver, the response return and the
// status and debug signals of uart_cmd_master.
//
// Handshake semantics:
//   cmd:  a command is taken on the rising clock edge where cmd_valid && cmd_ready.
//         The master raises cmd_ready only while idle. The request fields must be
//         valid in that cycle and are free to change afterwards.
//   tx:   a byte moves on the rising edge where tx_valid && tx_ready. Once
//         tx_valid is raised, tx_data stays constant and tx_valid stays high until
//         that transfer. Reset is the only exception: it withdraws tx_valid
//         immediately.
//   rx:   rx_valid is a single-cycle strobe with no back-pressure. The byte is
//         used only while the master is waiting for a response.
//   rsp:  rsp_valid (and rsp_timeout with it) pulses for one cycle.
//         rsp_data holds its value until the next command is accepted.
//
// Modports:
//   master - the uart_cmd_master side
//   slave  - the host / UART side
interface uart_cmd_master_if #(
  parameter int BUS_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int ALUFN_WIDTH = 4,
  parameter int ALU_WIDTH   = 16
);
  // command request
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_type;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [BUS_WIDTH-1:0]   cmd_wdata;
  logic [BUS_WIDTH-1:0]   cmd_op_a;
  logic [BUS_WIDTH-1:0]   cmd_op_b;
  logic [ALUFN_WIDTH-1:0] cmd_alu_fun;

  // byte stream to UART TX
  logic [BUS_WIDTH-1:0]   tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  // byte stream from UART RX
  logic [BUS_WIDTH-1:0]   rx_data;
  logic                   rx_valid;

  // response and status
  logic [ALU_WIDTH-1:0]   rsp_data;
  logic                   rsp_valid;
  logic                   rsp_timeout;
  logic                   busy;

  // FSM state for observation: 0 IDLE, 1 SEND, 2 WAIT_RSP, 3 DONE
  logic [1:0]             dbg_state;

  modport master (
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_alu_fun,
    input  tx_ready, rx_data, rx_valid,
    output cmd_ready, tx_data, tx_valid, rsp_data, rsp_valid, rsp_timeout, busy,
    output dbg_state
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_alu_fun,
    output tx_ready, rx_data, rx_valid,
    input  cmd_ready, tx_data, tx_valid, rsp_data, rsp_valid, rsp_timeout, busy,
    input  dbg_state
  );
endinterface

// File: rtl/uart_cmd_master.sv
// uart_cmd_master
//
// Host-side UART command initiator. It accepts one command and sends it as
// frame bytes on the TX byte stream. It then gathers the expected response bytes
// from the RX byte stream, least-significant byte first, and returns them as a
// single response word.
//
//   type 0 (RF write)     : AA, addr, wdata   -> no response bytes
//   type 1 (RF read)      : BB, addr          -> 1 response byte
//   type 2 (ALU operands) : CC, A, B, fun     -> 2 response bytes
//   type 3 (ALU only)     : DD, fun           -> 2 response bytes
//
// Ports:
//   CLK  - single clock
//   RST  - asynchronous, active-high reset; it aborts any frame in progress
//   bus  - uart_cmd_master_if.master (cmd / tx / rx / rsp / busy / dbg_state)
//
// Build option:
//   RSP_TIMEOUT_EN - when defined, a response gap of TIMEOUT_CYCLES cycles ends
//                    the command with rsp_valid and rsp_timeout pulsed together.
//                    When undefined, the block waits indefinitely for response
//                    bytes and rsp_timeout is held at 0.
module uart_cmd_master #(
  parameter int BUS_WIDTH      = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALUFN_WIDTH    = 4,
  parameter int ALU_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               CLK,
  input logic               RST,
  uart_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] T_WRITE   = 2'd0;
  localparam logic [1:0] T_READ    = 2'd1;
  localparam logic [1:0] T_ALU     = 2'd2;
  localparam logic [1:0] T_ALU_NOP = 2'd3;

  localparam logic [BUS_WIDTH-1:0] HDR_WRITE   = BUS_WIDTH'(8'hAA);
  localparam logic [BUS_WIDTH-1:0] HDR_READ    = BUS_WIDTH'(8'hBB);
  localparam logic [BUS_WIDTH-1:0] HDR_ALU     = BUS_WIDTH'(8'hCC);
  localparam logic [BUS_WIDTH-1:0] HDR_ALU_NOP = BUS_WIDTH'(8'hDD);

  // Elaboration-time guards on parameter combinations the datapath cannot handle.
  if (ALU_WIDTH != 2 * BUS_WIDTH) begin : g_bad_alu_width
    $error("uart_cmd_master: ALU_WIDTH must be exactly two frame bytes");
  end
  if (ADDR_WIDTH > BUS_WIDTH || ALUFN_WIDTH > BUS_WIDTH) begin : g_bad_field_width
    $error("uart_cmd_master: address and function must fit in one frame byte");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_cmd_master: TIMEOUT_CYCLES must be at least 2");
  end

  state_t                 state;
  state_t                 state_nxt;

  // Fields captured when the command is accepted
  logic [1:0]             type_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BUS_WIDTH-1:0]   wdata_q;
  logic [BUS_WIDTH-1:0]   op_a_q;
  logic [BUS_WIDTH-1:0]   op_b_q;
  logic [ALUFN_WIDTH-1:0] fun_q;

  logic [2:0]             byte_idx;   // frame byte currently presented
  logic                   rx_idx;     // response byte position (0 = low byte)
  logic [ALU_WIDTH-1:0]   rsp_data_q;

  logic [2:0]             last_byte;  // index of the final frame byte
  logic [1:0]             rsp_bytes;  // number of response bytes expected
  logic [BUS_WIDTH-1:0]   addr_byte;
  logic [BUS_WIDTH-1:0]   fun_byte;
  logic [BUS_WIDTH-1:0]   frame_byte;

  logic                   accept;
  logic                   tx_valid_int;
  logic                   tx_fire;
  logic                   tx_last;
  logic                   rx_take;
  logic                   rx_last;
  logic                   tmo_hit;

  assign accept       = (state == IDLE) && bus.cmd_valid;
  assign tx_valid_int = (state == SEND);
  assign tx_fire      = tx_valid_int && bus.tx_ready;
  assign tx_last      = (byte_idx == last_byte);
  // RX strobes are used only while a response is pending. Strays in
  // SEND, including one on the final TX transfer cycle, are dropped.
  assign rx_take      = (state == WAIT_RSP) && bus.rx_valid;
  assign rx_last      = rx_take && ({1'b0, rx_idx} == (rsp_bytes - 2'd1));

  assign addr_byte    = BUS_WIDTH'(addr_q);
  assign fun_byte     = BUS_WIDTH'(fun_q);

  // Frame length and response length for each command type
  always_comb begin
    last_byte = 3'd1;
    rsp_bytes = 2'd2;
    case (type_q)
      T_WRITE:   begin last_byte = 3'd2; rsp_bytes = 2'd0; end
      T_READ:    begin last_byte = 3'd1; rsp_bytes = 2'd1; end
      T_ALU:     begin last_byte = 3'd3; rsp_bytes = 2'd2; end
      T_ALU_NOP: begin last_byte = 3'd1; rsp_bytes = 2'd2; end
      default:   begin last_byte = 3'd1; rsp_bytes = 2'd2; end
    endcase
  end

  // Frame byte selection. It depends only on registered fields and byte_idx,
  // so tx_data cannot change while a byte is stalled.
  always_comb begin
    frame_byte = fun_byte;
    case (type_q)
      T_WRITE: begin
        case (byte_idx)
          3'd0:    frame_byte = HDR_WRITE;
          3'd1:    frame_byte = addr_byte;
          default: frame_byte = wdata_q;
        endcase
      end
      T_READ: begin
        case (byte_idx)
          3'd0:    frame_byte = HDR_READ;
          default: frame_byte = addr_byte;
        endcase
      end
      T_ALU: begin
        case (byte_idx)
          3'd0:    frame_byte = HDR_ALU;
          3'd1:    frame_byte = op_a_q;
          3'd2:    frame_byte = op_b_q;
          default: frame_byte = fun_byte;
        endcase
      end
      T_ALU_NOP: begin
        case (byte_idx)
          3'd0:    frame_byte = HDR_ALU_NOP;
          default: frame_byte = fun_byte;
        endcase
      end
      default: frame_byte = fun_byte;
    endcase
  end

`ifdef RSP_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             timed_out;

  // The counter measures cycles since entering WAIT_RSP or since the last
  // response byte. A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit = (state == WAIT_RSP) && !bus.rx_valid &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state != WAIT_RSP || bus.rx_valid) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (accept) begin
        timed_out <= 1'b0;
      end else if (tmo_hit) begin
        timed_out <= 1'b1;
      end
    end
  end

  assign bus.rsp_timeout = (state == DONE) && timed_out;
`else
  assign tmo_hit         = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) state_nxt = SEND;
      end
      SEND: begin
        if (tx_fire && tx_last) begin
          state_nxt = (type_q == T_WRITE) ? DONE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rx_last || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command capture, frame byte index and response assembly
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      type_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      fun_q      <= '0;
      byte_idx   <= 3'd0;
      rx_idx     <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        type_q     <= bus.cmd_type;
        addr_q     <= bus.cmd_addr;
        wdata_q    <= bus.cmd_wdata;
        op_a_q     <= bus.cmd_op_a;
        op_b_q     <= bus.cmd_op_b;
        fun_q      <= bus.cmd_alu_fun;
        byte_idx   <= 3'd0;
        rx_idx     <= 1'b0;
        rsp_data_q <= '0;
      end
      if (tx_fire) begin
        byte_idx <= byte_idx + 3'd1;
      end
      if (rx_take) begin
        if (!rx_idx) begin
          rsp_data_q[BUS_WIDTH-1:0] <= bus.rx_data;
        end else begin
          rsp_data_q[BUS_WIDTH +: BUS_WIDTH] <= bus.rx_data;
        end
        rx_idx <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.tx_valid  = tx_valid_int;
  assign bus.tx_data   = tx_valid_int ? frame_byte : '0;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = (state == DONE);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master
//
// Directed bench for uart_cmd_master. The scoreboard holds the expected TX frame
// bytes in exp_q, and a negedge monitor checks every transfer against it. The
// monitor also checks that stalled bytes are held and that rsp_valid is a pulse.
// Response words and latencies are compared with hand-derived values.
// TIMEOUT_CYCLES is shortened so that the timeout path (RSP_TIMEOUT_EN) runs
// quickly.
module tb_uart_cmd_master;
  localparam int BUS_WIDTH      = 8;
  localparam int ADDR_WIDTH     = 4;
  localparam int ALUFN_WIDTH    = 4;
  localparam int ALU_WIDTH      = 16;
  localparam int TIMEOUT_CYCLES = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_master_if #(
    .BUS_WIDTH(BUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .ALUFN_WIDTH(ALUFN_WIDTH), .ALU_WIDTH(ALU_WIDTH)
  ) bus ();

  uart_cmd_master #(
    .BUS_WIDTH(BUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .ALUFN_WIDTH(ALUFN_WIDTH),
    .ALU_WIDTH(ALU_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check task and counters ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [BUS_WIDTH-1:0] exp_q[$];
  int                   rsp_cnt = 0;
  int                   rsp_cyc = 0;
  int                   last_tx_cyc = 0;
  int                   rx_cyc = 0;
  logic [ALU_WIDTH-1:0] rsp_seen_data = '0;
  logic                 rsp_seen_tmo = 1'b0;
  logic                 prev_stall = 1'b0;
  logic                 prev_rsp = 1'b0;
  logic [BUS_WIDTH-1:0] prev_tx_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_rsp   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_valid", 32'(bus.tx_valid), 32'h1);
        check("tx_hold_data", 32'(bus.tx_data), 32'(prev_tx_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          check("tx_extra_byte", 32'(exp_q.size()), 32'h1);
        end else begin
          check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        last_tx_cyc = cyc;
      end
      if (bus.rsp_valid) begin
        check("rsp_single_pulse", 32'(prev_rsp), 32'h0);
        rsp_cnt++;
        rsp_cyc       = cyc;
        rsp_seen_data = bus.rsp_data;
        rsp_seen_tmo  = bus.rsp_timeout;
      end else if (bus.rsp_timeout) begin
        check("tmo_without_valid", 32'(bus.rsp_valid), 32'h1);
      end
      prev_stall   = bus.tx_valid && !bus.tx_ready;
      prev_tx_data = bus.tx_data;
      prev_rsp     = bus.rsp_valid;
    end
  end

  // tx_ready toggler used by the stall test
  bit rdy_toggle = 1'b0;
  always @(posedge clk) begin
    if (rdy_toggle) begin
      #1;
      bus.tx_ready = ~bus.tx_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wd,
                       input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
    bit accepted;
    int budget;
    bus.cmd_type    = t;
    bus.cmd_addr    = addr;
    bus.cmd_wdata   = wd;
    bus.cmd_op_a    = a;
    bus.cmd_op_b    = b;
    bus.cmd_alu_fun = fun;
    bus.cmd_valid   = 1'b1;
    accepted = 1'b0;
    budget   = 0;
    while (!accepted && budget < 200) begin
      accepted = bus.cmd_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    bus.cmd_valid = 1'b0;
    // Scramble the request fields to show they were captured at acceptance
    bus.cmd_type    = 2'($urandom_range(0, 3));
    bus.cmd_addr    = 4'($urandom_range(0, 15));
    bus.cmd_wdata   = 8'($urandom_range(0, 255));
    bus.cmd_op_a    = 8'($urandom_range(0, 255));
    bus.cmd_op_b    = 8'($urandom_range(0, 255));
    bus.cmd_alu_fun = 4'($urandom_range(0, 15));
    check("cmd_accepted", 32'(accepted), 32'h1);
    check("tx_valid_rise", 32'(bus.tx_valid), 32'h1);
  endtask

  task automatic send_rx(input logic [7:0] d);
    sync();
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    rx_cyc       = cyc;
    sync();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_rsp(input int budget);
    int start;
    int n;
    start = rsp_cnt;
    n     = 0;
    while (rsp_cnt == start && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_seen", 32'(rsp_cnt - start), 32'h1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("tx_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    err_cnt++;
    summary();
    $finish;
  end

  // ---------------- directed sequence ----------------
  int cnt_before;

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_type    = 2'd0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.cmd_op_a    = '0;
    bus.cmd_op_b    = '0;
    bus.cmd_alu_fun = '0;
    bus.tx_ready    = 1'b1;
    bus.rx_data     = '0;
    bus.rx_valid    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'h0);
    sync();
    rst = 1'b0;
    idle(2);

    // Type 0: RF write, no response bytes
    exp_q.push_back(8'hAA); exp_q.push_back(8'h05); exp_q.push_back(8'h3C);
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    wait_rsp(20);
    check("t0_rsp_data", 32'(rsp_seen_data), 32'h0000);
    check("t0_rsp_tmo", 32'(rsp_seen_tmo), 32'h0);
    check("t0_rsp_latency", 32'(rsp_cyc - last_tx_cyc), 32'h1);
    check("t0_tx_drained", 32'(exp_q.size()), 32'h0);

    // Type 1: RF read, response byte arrives after 50 cycles
    exp_q.push_back(8'hBB); exp_q.push_back(8'h02);
    issue(2'd1, 4'h2, 8'hFF, 8'hFF, 8'hFF, 4'hF);
    wait_drain(20);
    idle(50);
    check("t1_busy_waiting", 32'(bus.busy), 32'h1);
    check("t1_state_wait", 32'(bus.dbg_state), 32'h2);
    send_rx(8'h81);
    wait_rsp(20);
    check("t1_rsp_data", 32'(rsp_seen_data), 32'h0081);
    check("t1_rsp_latency", 32'(rsp_cyc - rx_cyc), 32'h1);
    idle(3);
    check("t1_rsp_held", 32'(bus.rsp_data), 32'h0081);
    check("t1_idle_after", 32'(bus.busy), 32'h0);

    // Type 2 with tx_ready toggling every cycle
    rdy_toggle = 1'b1;
    exp_q.push_back(8'hCC); exp_q.push_back(8'h12);
    exp_q.push_back(8'h34); exp_q.push_back(8'h00);
    issue(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0);
    check("t2_rsp_cleared", 32'(bus.rsp_data), 32'h0000);
    wait_drain(40);
    rdy_toggle = 1'b0;
    sync();
    bus.tx_ready = 1'b1;
    send_rx(8'h46);
    send_rx(8'h00);
    wait_rsp(20);
    check("t2_rsp_data", 32'(rsp_seen_data), 32'h0046);
    check("t2_rsp_latency", 32'(rsp_cyc - rx_cyc), 32'h1);

    // Type 3: stray rx during SEND and on the final transfer, held cmd_valid
    sync();
    bus.tx_ready = 1'b0;
    exp_q.push_back(8'hDD); exp_q.push_back(8'h02);
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
    bus.rx_valid = 1'b1;          // stray byte while the header is stalled
    bus.rx_data  = 8'h77;
    sync();
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;          // header moves on the next edge
    sync();
    bus.rx_valid = 1'b1;          // coincides with the final frame byte transfer
    bus.rx_data  = 8'h99;
    sync();
    bus.rx_valid = 1'b0;
    check("t3_tx_drained", 32'(exp_q.size()), 32'h0);
    check("t3_state_wait", 32'(bus.dbg_state), 32'h2);
    bus.cmd_type    = 2'd1;       // next request held high while busy
    bus.cmd_addr    = 4'h9;
    bus.cmd_valid   = 1'b1;
    send_rx(8'h08);
    check("t3_ready_while_busy", 32'(bus.cmd_ready), 32'h0);
    send_rx(8'h04);
    wait_rsp(20);
    check("t3_rsp_data", 32'(rsp_seen_data), 32'h0408);
    check("t3_rsp_latency", 32'(rsp_cyc - rx_cyc), 32'h1);
    check("t3_ready_in_done", 32'(bus.cmd_ready), 32'h0);
    exp_q.push_back(8'hBB); exp_q.push_back(8'h09);
    issue(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_drain(20);
    send_rx(8'hE1);
    wait_rsp(20);
    check("t3_next_rsp_data", 32'(rsp_seen_data), 32'h00E1);

    // Type 2 with only one response byte: timeout path
    exp_q.push_back(8'hCC); exp_q.push_back(8'h9A);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h07);
    issue(2'd2, 4'h0, 8'h00, 8'h9A, 8'h0F, 4'h7);
    wait_drain(20);
    send_rx(8'h55);
`ifdef RSP_TIMEOUT_EN
    wait_rsp(TIMEOUT_CYCLES + 20);
    check("tmo_rsp_timeout", 32'(rsp_seen_tmo), 32'h1);
    check("tmo_rsp_data", 32'(rsp_seen_data), 32'h0055);
    check("tmo_latency", 32'(rsp_cyc - rx_cyc), 32'(TIMEOUT_CYCLES + 1));
    @(negedge clk);
    check("tmo_pulse_drop", 32'(bus.rsp_timeout), 32'h0);
`else
    cnt_before = rsp_cnt;
    idle(3 * TIMEOUT_CYCLES);
    check("notmo_busy", 32'(bus.busy), 32'h1);
    check("notmo_no_rsp", 32'(rsp_cnt - cnt_before), 32'h0);
    check("notmo_tmo_low", 32'(bus.rsp_timeout), 32'h0);
    send_rx(8'h00);
    wait_rsp(20);
    check("notmo_rsp_data", 32'(rsp_seen_data), 32'h0055);
    check("notmo_rsp_tmo", 32'(rsp_seen_tmo), 32'h0);
`endif

    // Reset while the third byte of a type 2 frame is stalled
    sync();
    bus.tx_ready = 1'b1;
    exp_q.push_back(8'hCC); exp_q.push_back(8'h21);
    issue(2'd2, 4'h0, 8'h00, 8'h21, 8'h43, 4'h5);
    sync();
    sync();
    bus.tx_ready = 1'b0;
    @(negedge clk);
    check("rst_third_byte", 32'(bus.tx_data), 32'h43);
    cnt_before = rsp_cnt;
    #1;
    rst = 1'b1;
    #1;
    check("abort_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("abort_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    sync();
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    idle(10);
    check("abort_no_rsp", 32'(rsp_cnt - cnt_before), 32'h0);
    check("abort_tx_consumed", 32'(exp_q.size()), 32'h0);
    exp_q.push_back(8'hBB); exp_q.push_back(8'h0F);
    issue(2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_drain(20);
    send_rx(8'hC3);
    wait_rsp(20);
    check("post_rst_rsp_data", 32'(rsp_seen_data), 32'h00C3);

    idle(3);
    summary();
    $finish;
  end

endmodule
